// File: rtl/json_motor_rx.sv
// json_motor_rx
//
// 8N1 UART receiver plus a byte-serial parser for motor command lines of the
// form {"T":1,"L":-0.5,"R":-0.5}<newline>. T is an unsigned integer; L and R
// are signed fixed-point values reported in thousandths.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   uart_in    serial line, idle high, LSB first, one stop bit, no parity
//   msg_valid  one-cycle pulse when a complete line is committed to the outputs
//   msg_type   unsigned T of the last committed line
//   left       signed L (thousandths) of the last committed line
//   right      signed R (thousandths) of the last committed line
//   msg_error  one-cycle pulse on a rejected line or a framing error
//   dbg_state  {receiver state[1:0], parser state[3:0]} for observation
//
// Handshake: there is no back-pressure. msg_valid and msg_error are
// single-cycle strobes, never asserted together; msg_type/left/right change
// only in the cycle msg_valid is high and hold their value otherwise.
module json_motor_rx #(
    parameter int CLKS_PER_BIT = 50_000_000 / 115_200,
    parameter int MAX_LEN      = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_in,
    output logic        msg_valid,
    output logic [15:0] msg_type,
    output logic [15:0] left,
    output logic [15:0] right,
    output logic        msg_error,
    output logic [5:0]  dbg_state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    // Receiver states
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // Parser states
    localparam logic [3:0] P_IDLE      = 4'd0;
    localparam logic [3:0] P_KEY_Q1    = 4'd1;
    localparam logic [3:0] P_KEY       = 4'd2;
    localparam logic [3:0] P_KEY_Q2    = 4'd3;
    localparam logic [3:0] P_COLON     = 4'd4;
    localparam logic [3:0] P_VAL_SIGN  = 4'd5;
    localparam logic [3:0] P_VAL_INT   = 4'd6;
    localparam logic [3:0] P_VAL_FRAC  = 4'd7;
    localparam logic [3:0] P_AFTER_VAL = 4'd8;
    localparam logic [3:0] P_WAIT_NL   = 4'd9;

    localparam logic [1:0] KEY_T = 2'd0;
    localparam logic [1:0] KEY_L = 2'd1;
    localparam logic [1:0] KEY_R = 2'd2;

    // ------------------------------------------------------------------
    // Synchroniser. Everything resets to 0 so a line that is low when reset
    // releases cannot look like a falling edge: line_prev only goes high
    // once the real line has been seen high.
    // ------------------------------------------------------------------
    logic sync1, sync2, line_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            line_prev <= 1'b0;
        end else begin
            sync1     <= uart_in;
            sync2     <= sync1;
            line_prev <= sync2;
        end
    end

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    logic [1:0]       rx_state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_byte;
    logic             byte_stb;
    logic             frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= 3'd0;
            rx_byte  <= 8'd0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (line_prev && !sync2) begin
                        rx_state <= RX_START;
                        cnt      <= '0;
                    end
                end
                RX_START: begin
                    // Mid-start re-check rejects glitches shorter than half a bit.
                    if (cnt == HALF_LAST) begin
                        cnt      <= '0;
                        bit_idx  <= 3'd0;
                        rx_state <= sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        rx_byte <= {sync2, rx_byte[7:1]};
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // Return to idle right at the stop-bit centre so a start
                    // bit following with no gap is still caught.
                    if (cnt == BIT_LAST) begin
                        cnt      <= '0;
                        rx_state <= RX_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign byte_stb  = (rx_state == RX_STOP) && (cnt == BIT_LAST) &&  sync2;
    assign frame_err = (rx_state == RX_STOP) && (cnt == BIT_LAST) && !sync2;

    // ------------------------------------------------------------------
    // Parser
    // ------------------------------------------------------------------
    logic [3:0]       p_state;
    logic [1:0]       key;
    logic [15:0]      acc;
    logic             neg;
    logic [2:0]       ndig;
    logic [1:0]       nfrac;
    logic [2:0]       seen;
    logic [15:0]      sh_t, sh_l, sh_r;
    logic [LEN_W-1:0] len;

    logic        is_digit;
    logic [15:0] digit_w;
    logic [15:0] acc_x10;
    logic [15:0] int_lr;
    logic [15:0] frac_add;
    logic [15:0] signed_val;
    logic        in_line;
    logic        is_term;
    logic        val_end;

    assign is_digit   = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
    assign digit_w    = {12'd0, rx_byte[3:0]};
    assign acc_x10    = acc * 16'd10;
    assign int_lr     = digit_w * 16'd1000;
    assign signed_val = neg ? (16'd0 - acc) : acc;
    assign in_line    = (p_state != P_IDLE) && (p_state != P_WAIT_NL);
    assign is_term    = (rx_byte == 8'h2C) || (rx_byte == 8'h7D) || (rx_byte == 8'h20);
    // A space inside a number terminates it; AFTER_VAL then waits for , or }.
    assign val_end    = is_term &&
                        (((p_state == P_VAL_INT)  && (ndig  != 3'd0)) ||
                         ((p_state == P_VAL_FRAC) && (nfrac != 2'd0)));

    always_comb begin
        frac_add = 16'd0;
        case (nfrac)
            2'd0:    frac_add = digit_w * 16'd100;
            2'd1:    frac_add = digit_w * 16'd10;
            default: frac_add = digit_w;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_state   <= P_IDLE;
            key       <= KEY_T;
            acc       <= 16'd0;
            neg       <= 1'b0;
            ndig      <= 3'd0;
            nfrac     <= 2'd0;
            seen      <= 3'd0;
            sh_t      <= 16'd0;
            sh_l      <= 16'd0;
            sh_r      <= 16'd0;
            len       <= '0;
            msg_valid <= 1'b0;
            msg_error <= 1'b0;
            msg_type  <= 16'd0;
            left      <= 16'd0;
            right     <= 16'd0;
        end else begin
            msg_valid <= 1'b0;
            msg_error <= 1'b0;
            if (frame_err) begin
                msg_error <= 1'b1;
                p_state   <= P_IDLE;
            end else if (byte_stb) begin
                if ((p_state != P_IDLE) && (rx_byte == 8'h7B)) begin
                    // Unexpected '{': drop this line, start a new one.
                    msg_error <= 1'b1;
                    p_state   <= P_KEY_Q1;
                    len       <= LEN_W'(1);
                    seen      <= 3'd0;
                end else if (in_line && (len == LEN_MAX)) begin
                    msg_error <= 1'b1;
                    p_state   <= P_IDLE;
                end else begin
                    if (in_line) begin
                        len <= len + 1'b1;
                    end
                    if (val_end) begin
                        case (key)
                            KEY_T: begin sh_t <= signed_val; seen[0] <= 1'b1; end
                            KEY_L: begin sh_l <= signed_val; seen[1] <= 1'b1; end
                            default: begin sh_r <= signed_val; seen[2] <= 1'b1; end
                        endcase
                        if (rx_byte == 8'h2C)      p_state <= P_KEY_Q1;
                        else if (rx_byte == 8'h7D) p_state <= P_WAIT_NL;
                        else                       p_state <= P_AFTER_VAL;
                    end else if ((rx_byte == 8'h20) && (p_state != P_VAL_INT) &&
                                 (p_state != P_VAL_FRAC)) begin
                        // space outside a number: ignored
                    end else begin
                        case (p_state)
                            P_IDLE: begin
                                if (rx_byte == 8'h7B) begin
                                    p_state <= P_KEY_Q1;
                                    len     <= LEN_W'(1);
                                    seen    <= 3'd0;
                                end
                            end
                            P_KEY_Q1: begin
                                if (rx_byte == 8'h22) p_state <= P_KEY;
                                else begin msg_error <= 1'b1; p_state <= P_IDLE; end
                            end
                            P_KEY: begin
                                if (rx_byte == 8'h54)      begin key <= KEY_T; p_state <= P_KEY_Q2; end
                                else if (rx_byte == 8'h4C) begin key <= KEY_L; p_state <= P_KEY_Q2; end
                                else if (rx_byte == 8'h52) begin key <= KEY_R; p_state <= P_KEY_Q2; end
                                else begin msg_error <= 1'b1; p_state <= P_IDLE; end
                            end
                            P_KEY_Q2: begin
                                if (rx_byte == 8'h22) p_state <= P_COLON;
                                else begin msg_error <= 1'b1; p_state <= P_IDLE; end
                            end
                            P_COLON: begin
                                if (rx_byte == 8'h3A) begin
                                    p_state <= P_VAL_SIGN;
                                    acc     <= 16'd0;
                                    neg     <= 1'b0;
                                    ndig    <= 3'd0;
                                    nfrac   <= 2'd0;
                                end else begin
                                    msg_error <= 1'b1;
                                    p_state   <= P_IDLE;
                                end
                            end
                            P_VAL_SIGN: begin
                                if ((rx_byte == 8'h2D) && (key != KEY_T)) begin
                                    neg     <= 1'b1;
                                    p_state <= P_VAL_INT;
                                end else if (is_digit) begin
                                    acc     <= (key == KEY_T) ? digit_w : int_lr;
                                    ndig    <= 3'd1;
                                    p_state <= P_VAL_INT;
                                end else begin
                                    msg_error <= 1'b1;
                                    p_state   <= P_IDLE;
                                end
                            end
                            P_VAL_INT: begin
                                if (is_digit && (key == KEY_T) && (ndig != 3'd4)) begin
                                    acc  <= acc_x10 + digit_w;
                                    ndig <= ndig + 1'b1;
                                end else if (is_digit && (key != KEY_T) && (ndig == 3'd0)) begin
                                    acc  <= int_lr;
                                    ndig <= 3'd1;
                                end else if ((rx_byte == 8'h2E) && (key != KEY_T) && (ndig != 3'd0)) begin
                                    p_state <= P_VAL_FRAC;
                                end else begin
                                    msg_error <= 1'b1;
                                    p_state   <= P_IDLE;
                                end
                            end
                            P_VAL_FRAC: begin
                                if (is_digit && (nfrac != 2'd3)) begin
                                    acc   <= acc + frac_add;
                                    nfrac <= nfrac + 1'b1;
                                end else begin
                                    msg_error <= 1'b1;
                                    p_state   <= P_IDLE;
                                end
                            end
                            P_AFTER_VAL: begin
                                if (rx_byte == 8'h2C)      p_state <= P_KEY_Q1;
                                else if (rx_byte == 8'h7D) p_state <= P_WAIT_NL;
                                else begin msg_error <= 1'b1; p_state <= P_IDLE; end
                            end
                            P_WAIT_NL: begin
                                if (rx_byte == 8'h0A) begin
                                    p_state <= P_IDLE;
                                    if (seen == 3'b111) begin
                                        msg_valid <= 1'b1;
                                        msg_type  <= sh_t;
                                        left      <= sh_l;
                                        right     <= sh_r;
                                    end else begin
                                        msg_error <= 1'b1;
                                    end
                                end else if (rx_byte != 8'h0D) begin
                                    msg_error <= 1'b1;
                                    p_state   <= P_IDLE;
                                end
                            end
                            default: p_state <= P_IDLE;
                        endcase
                    end
                end
            end
        end
    end

    assign dbg_state = {rx_state, p_state};

endmodule

// File: tb/tb_json_motor_rx.sv
module tb_json_motor_rx;
  localparam int CPB = 8;
  localparam int MAX_LEN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_in = 1'b1;
  logic        msg_valid, msg_error;
  logic [15:0] msg_type, left, right;
  logic [5:0]  dbg_state;

  json_motor_rx #(.CLKS_PER_BIT(CPB), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .uart_in(uart_in),
    .msg_valid(msg_valid), .msg_type(msg_type), .left(left), .right(right),
    .msg_error(msg_error), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  // scoreboard: {is_valid, msg_type, left, right} per expected pulse
  logic [48:0] exp_q[$];
  logic [15:0] hold_t = 16'd0, hold_l = 16'd0, hold_r = 16'd0;
  int val_cnt = 0, err_cnt = 0, err_cyc = 0;
  logic prev_pulse = 1'b0;

  always @(negedge clk) begin
    logic [48:0] e, got;
    if (!rst && (msg_valid || msg_error)) begin
      if (msg_valid) val_cnt++;
      if (msg_error) begin err_cnt++; err_cyc = cyc; end
      tests_run++;
      if (msg_valid && msg_error) begin
        tests_failed++;
        $display("FAIL both_pulses: valid=%b error=%b, required not both", msg_valid, msg_error);
      end
      tests_run++;
      if (prev_pulse) begin
        tests_failed++;
        $display("FAIL pulse_width: pulse in consecutive cycles at cyc %0d, required 1 cycle", cyc);
      end
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_event: valid=%b error=%b at cyc %0d, required no pulse", msg_valid, msg_error, cyc);
      end else begin
        e = exp_q.pop_front();
        got = {msg_valid, msg_type, left, right};
        tests_run++;
        if (got !== e) begin
          tests_failed++;
          $display("FAIL event: got v=%b t=%h l=%h r=%h, required v=%b t=%h l=%h r=%h",
                   got[48], got[47:32], got[31:16], got[15:0], e[48], e[47:32], e[31:16], e[15:0]);
        end
      end
    end
    prev_pulse = !rst && (msg_valid || msg_error);
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      tick(CPB);
    end
    uart_in = stop;
    tick(CPB);
    uart_in = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic exp_valid(input int t, input int l, input int r);
    hold_t = 16'(t);
    hold_l = 16'(l);
    hold_r = 16'(r);
    exp_q.push_back({1'b1, hold_t, hold_l, hold_r});
  endtask

  task automatic exp_error();
    exp_q.push_back({1'b0, hold_t, hold_l, hold_r});
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    uart_in = 1'b1;
    tick(4);
    tests_run++;
    if ({msg_valid, msg_error} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_pulses: got %b, required 00", {msg_valid, msg_error});
    end
    tests_run++;
    if ({msg_type, left, right} !== 48'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h, required 0", {msg_type, left, right});
    end
    tests_run++;
    if (dbg_state !== 6'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got %h, required 0", dbg_state);
    end
    rst = 1'b0;
    tick(3 * CPB);
  endtask

  task automatic check_drained(input string name);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain: %0d expected pulses missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
    tests_run++;
    if ({msg_type, left, right} !== {hold_t, hold_l, hold_r}) begin
      tests_failed++;
      $display("FAIL %s_hold: got %h, required %h", name, {msg_type, left, right}, {hold_t, hold_l, hold_r});
    end
  endtask

  task automatic test_basic();
    exp_valid(1, -500, -500);
    send_str("{\"T\":1,\"L\":-0.5,\"R\":-0.5}\n\n");
    tick(2 * CPB);
    check_drained("basic");
    tests_run++;
    if (left !== 16'hFE0C) begin
      tests_failed++;
      $display("FAIL basic_left: got %h, required fe0c", left);
    end
  endtask

  task automatic test_spaces_cr();
    exp_valid(1001, 1000, 250);
    send_str("{\"R\":0.25, \"L\":1,\"T\":1001}\r\n");
    tick(2 * CPB);
    check_drained("spaces_cr");
  endtask

  task automatic test_malformed();
    int c_e;
    send_str("{\"T\":1,\"L\":1");
    exp_error();
    c_e = err_cnt;
    send_str("2");
    tick(CPB);
    tests_run++;
    if (err_cnt != c_e + 1) begin
      tests_failed++;
      $display("FAIL second_int_digit: %0d errors at '2', required 1", err_cnt - c_e);
    end
    send_str(",\"R\":0}\n");
    tick(2 * CPB);
    check_drained("second_int_digit");
    send_str("{\"T\":1,\"L\":0}");
    c_e = err_cnt;
    tick(CPB);
    tests_run++;
    if (err_cnt != c_e) begin
      tests_failed++;
      $display("FAIL missing_key_early: %0d errors before newline, required 0", err_cnt - c_e);
    end
    exp_error();
    send_str("\n");
    tick(2 * CPB);
    check_drained("missing_key");
  endtask

  string bad_lines[6] = '{
    "{\"X\":1}\n",
    "{\"T\":-1}\n",
    "{\"T\":12345}\n",
    "{\"L\":1.}\n",
    "{\"L\":1.2345}\n",
    "{\"T\":}\n"
  };

  task automatic test_bad_table();
    for (int i = 0; i < 6; i++) begin
      exp_error();
      send_str(bad_lines[i]);
      tick(2 * CPB);
      check_drained($sformatf("bad_%0d", i));
    end
  endtask

  task automatic test_restart();
    exp_error();
    exp_valid(1, 0, 0);
    send_str("{\"T\":1,{\"T\":1,\"L\":0,\"R\":0}\n");
    tick(2 * CPB);
    check_drained("restart");
  endtask

  task automatic test_max_len();
    exp_valid(7, -500, -500);
    send_str("{\"T\":7,       \"L\":-0.5,\"R\":-0.5}\n");
    tick(2 * CPB);
    check_drained("len_32");
    exp_error();
    send_str("{\"T\":8,        \"L\":-0.5,\"R\":-0.5}\n");
    tick(2 * CPB);
    check_drained("len_33");
  endtask

  task automatic test_framing();
    int c_e, stop_end;
    send_str("{\"T\":2,\"L\":");
    exp_error();
    c_e = err_cnt;
    send_byte(8'h30, 1'b0);
    stop_end = cyc;
    for (int i = 0; i < 2 * CPB && err_cnt == c_e; i++) tick(1);
    tests_run++;
    if (err_cnt == c_e) begin
      tests_failed++;
      $display("FAIL framing_timeout: no msg_error within %0d cycles of bad stop bit", 2 * CPB);
    end else begin
      tests_run++;
      if (err_cyc < stop_end - CPB || err_cyc > stop_end + CPB) begin
        tests_failed++;
        $display("FAIL framing_timing: error at cyc %0d, required within stop bit ending %0d", err_cyc, stop_end);
      end
    end
    tick(2 * CPB);
    send_str("0,\"R\":0}\n");
    tick(2 * CPB);
    check_drained("framing");
  endtask

  task automatic test_reset_mid();
    send_str("{\"T\":1,\"L");
    // byte 10 is '"' = 8'h22; abort it during data bit 2
    uart_in = 1'b0; tick(CPB);
    uart_in = 1'b0; tick(CPB);
    uart_in = 1'b1; tick(CPB);
    uart_in = 1'b0; tick(CPB / 2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    hold_t = 16'd0;
    hold_l = 16'd0;
    hold_r = 16'd0;
    tests_run++;
    if ({msg_type, left, right} !== 48'd0 || dbg_state !== 6'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: outputs %h state %h, required 0 and 0", {msg_type, left, right}, dbg_state);
    end
    tick(CPB / 2 - 1);
    tick(2 * CPB);
    uart_in = 1'b1;
    tick(3 * CPB);
    check_drained("reset_mid_quiet");
    exp_valid(1, -500, -500);
    send_str("{\"T\":1,\"L\":-0.5,\"R\":-0.5}\n");
    tick(2 * CPB);
    check_drained("reset_mid_after");
  endtask

  task automatic test_glitch();
    int c_v, c_e;
    c_v = val_cnt;
    c_e = err_cnt;
    uart_in = 1'b0;
    tick(1);
    uart_in = 1'b1;
    tick(4 * CPB);
    tests_run++;
    if (val_cnt != c_v || err_cnt != c_e || dbg_state[5:4] !== 2'd0) begin
      tests_failed++;
      $display("FAIL glitch: %0d valid %0d error rx_state %0d, required 0 0 0",
               val_cnt - c_v, err_cnt - c_e, dbg_state[5:4]);
    end
  endtask

  task automatic test_back_to_back();
    exp_valid(3, 125, -9999);
    exp_valid(9999, -1000, 2500);
    send_str("{\"T\":3,\"L\":0.125,\"R\":-9.999}\n{\"T\":9999,\"L\":-1,\"R\":2.5}\n");
    tick(2 * CPB);
    check_drained("back_to_back");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_spaces_cr();
    test_malformed();
    test_bad_table();
    test_restart();
    test_max_len();
    test_framing();
    test_reset_mid();
    test_glitch();
    test_back_to_back();
    tick(4);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
